tc_copy_engine: RTL and testbench

- Initiator for the TC load/save storage interface. It drives load strobes and read addresses into a source storage bank and save strobes, write addresses and data into a destination bank.
- Copies a block of COUNT words, one word per clock, fully pipelined.
- Sits beside register/RAM components as a simple DMA sequencer and is started by a one-cycle pulse.
- Targets storage with these semantics:
  - load is sampled at posedge; the storage output is registered and reads zero when load is low.
  - save is sampled at the following negedge.

---
 rtl/tc_copy_engine.sv | 178 +++++++++++++++++
 tb/tb_tc_copy_engine.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tc_copy_engine.sv
// tc_copy_engine
//
// Block-copy sequencer for the TC load/save storage interface. After a
// one-cycle start pulse it streams COUNT words from a source bank to a
// destination bank, one word per clock. It uses a three-stage pipeline:
// issue load, capture rd_data, issue save.
//
// Strobe semantics: the source bank samples rd_load/rd_addr at posedge and
// presents registered data (zero when not loaded) in the following cycle.
// The destination bank samples wr_save/wr_addr/wr_data at the negedge of
// the cycle the strobe is high. There is no back-pressure. A strobe high in a
// cycle is a completed transfer.
//
// Ports
//   clk        single clock, all state changes on posedge
//   rst        asynchronous, active-low reset
//   start      one-cycle request (accepted only in IDLE)
//   abort      cancel the running transfer (honoured in RUN/DRAIN)
//   src_base   first source address      (latched on accepted start)
//   dst_base   first destination address (latched on accepted start)
//   count      words to copy, 0..2^ADDR_WIDTH (latched on accepted start)
//   rd_load    load strobe to source bank
//   rd_addr    source address
//   rd_data    source bank output, valid the cycle after rd_load
//   wr_save    save strobe to destination bank
//   wr_addr    destination address
//   wr_data    destination data, zero whenever wr_save is low
//   busy       high from accept until the done cycle
//   done       one-cycle completion pulse
//   aborted    qualifies done: transfer was cancelled
//   words_done words saved in the current or last transfer
module tc_copy_engine #(
    parameter int    BIT_WIDTH  = 8,
    parameter int    ADDR_WIDTH = 8,
    parameter int    UUID       = 0,
    parameter string NAME       = ""
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] src_base,
    input  logic [ADDR_WIDTH-1:0] dst_base,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  rd_load,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [BIT_WIDTH-1:0]  rd_data,
    output logic                  wr_save,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [BIT_WIDTH-1:0]  wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  aborted,
    output logic [ADDR_WIDTH:0]   words_done
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_DRAIN  = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    localparam logic [ADDR_WIDTH:0] CNT_ZERO = '0;
    localparam logic [ADDR_WIDTH:0] CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};

    logic [1:0]            state;
    // rd_data is valid in this cycle (a load was issued in the previous one)
    logic                  dvalid;
    // loads still to be issued after the current one
    logic [ADDR_WIDTH:0]   reads_left;
    // destination address for the next captured word
    logic [ADDR_WIDTH-1:0] wr_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            dvalid     <= 1'b0;
            reads_left <= '0;
            wr_next    <= '0;
            rd_load    <= 1'b0;
            rd_addr    <= '0;
            wr_save    <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            words_done <= '0;
        end else begin
            done    <= 1'b0;
            aborted <= 1'b0;

            // Pipeline stages 2 and 3 advance every cycle. The FSM below only
            // controls load issue, and it flushes these stages on abort.
            dvalid  <= rd_load;
            wr_save <= dvalid;
            wr_data <= dvalid ? rd_data : '0;
            if (dvalid) begin
                wr_addr <= wr_next;
                wr_next <= wr_next + 1'b1;
            end
            // A save strobed in the cycle now ending has already landed.
            // This also holds on an abort edge.
            if (wr_save) begin
                words_done <= words_done + 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        words_done <= '0;
                        if (count != CNT_ZERO) begin
                            rd_load    <= 1'b1;
                            rd_addr    <= src_base;
                            wr_next    <= dst_base;
                            reads_left <= count - 1'b1;
                            busy       <= 1'b1;
                            state      <= (count == CNT_ONE) ? S_DRAIN : S_RUN;
                        end else begin
                            // Empty request: complete at once, never busy.
                            done <= 1'b1;
                        end
                    end
                end

                S_RUN: begin
                    if (abort) begin
                        rd_load <= 1'b0;
                        dvalid  <= 1'b0;
                        wr_save <= 1'b0;
                        wr_data <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        state   <= S_FINISH;
                    end else begin
                        rd_load    <= 1'b1;
                        rd_addr    <= rd_addr + 1'b1;
                        reads_left <= reads_left - 1'b1;
                        if (reads_left == CNT_ONE) begin
                            state <= S_DRAIN;
                        end
                    end
                end

                S_DRAIN: begin
                    if (abort) begin
                        rd_load <= 1'b0;
                        dvalid  <= 1'b0;
                        wr_save <= 1'b0;
                        wr_data <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        aborted <= 1'b1;
                        state   <= S_FINISH;
                    end else begin
                        rd_load <= 1'b0;
                        // Once no load or capture is pending, the save in
                        // this cycle (if any) is the last one.
                        if (!rd_load && !dvalid) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= S_FINISH;
                        end
                    end
                end

                S_FINISH: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tc_copy_engine.sv
module tb_tc_copy_engine;

    localparam int BW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] src_base = '0;
    logic [AW-1:0] dst_base = '0;
    logic [AW:0]   count = '0;
    logic          rd_load;
    logic [AW-1:0] rd_addr;
    logic [BW-1:0] rd_data = '0;
    logic          wr_save;
    logic [AW-1:0] wr_addr;
    logic [BW-1:0] wr_data;
    logic          busy;
    logic          done;
    logic          aborted;
    logic [AW:0]   words_done;

    logic [BW-1:0] src_mem [16];
    logic [BW-1:0] dst_mem [16];
    logic          fill_req = 1'b0;
    logic [BW-1:0] fill_val = '0;

    int n_cmp = 0;
    int n_err = 0;

    tc_copy_engine #(.BIT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src_base(src_base), .dst_base(dst_base), .count(count),
        .rd_load(rd_load), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_save(wr_save), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done), .aborted(aborted), .words_done(words_done)
    );

    // clock / reset block
    always #5 clk = ~clk;

    // source bank: load sampled at posedge, registered output, zero when idle
    always @(posedge clk) rd_data <= rd_load ? src_mem[rd_addr] : '0;

    // destination bank: save sampled at negedge
    always @(negedge clk) begin
        if (fill_req) begin
            for (int i = 0; i < 16; i++) dst_mem[i] <= fill_val;
        end else if (wr_save) begin
            dst_mem[wr_addr] <= wr_data;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One cycle of expected strobes/status; addresses checked only when strobed.
    task automatic cyc(input string tag, input bit rl, input int ra, input bit ws,
                       input int wa, input int wd, input bit bz, input bit dn, input bit ab);
        chk($sformatf("%s rd_load", tag), {31'd0, rd_load}, {31'd0, rl});
        if (rl) chk($sformatf("%s rd_addr", tag), {28'd0, rd_addr}, ra);
        chk($sformatf("%s wr_save", tag), {31'd0, wr_save}, {31'd0, ws});
        if (ws) chk($sformatf("%s wr_addr", tag), {28'd0, wr_addr}, wa);
        chk($sformatf("%s wr_data", tag), {24'd0, wr_data}, wd);
        chk($sformatf("%s busy", tag), {31'd0, busy}, {31'd0, bz});
        chk($sformatf("%s done", tag), {31'd0, done}, {31'd0, dn});
        chk($sformatf("%s aborted", tag), {31'd0, aborted}, {31'd0, ab});
    endtask

    task automatic do_start(input int s, input int d, input int c);
        src_base = s[AW-1:0];
        dst_base = d[AW-1:0];
        count    = c[AW:0];
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    task automatic fill_dst(input logic [BW-1:0] v);
        fill_val = v;
        fill_req = 1'b1;
        tick();
        fill_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) src_mem[i] = 8'h10 + 8'(i);

        // reset state
        tick();
        tick();
        cyc("rst", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("rst rd_addr", {28'd0, rd_addr}, 0);
        chk("rst wr_addr", {28'd0, wr_addr}, 0);
        chk("rst words_done", {27'd0, words_done}, 0);
        rst = 1'b1;
        tick();

        // basic copy 2->9, 3 words; start while busy in cycle 2 is ignored
        do_start(2, 9, 3);
        cyc("t1 c1", 1, 2, 0, 0, 0, 1, 0, 0);
        tick();
        cyc("t1 c2", 1, 3, 0, 0, 0, 1, 0, 0);
        src_base = 4'd0; dst_base = 4'd0; count = 5'd7; start = 1'b1;
        tick();
        start = 1'b0;
        cyc("t1 c3", 1, 4, 1, 9, 8'h12, 1, 0, 0);
        tick();
        cyc("t1 c4", 0, 0, 1, 10, 8'h13, 1, 0, 0);
        tick();
        cyc("t1 c5", 0, 0, 1, 11, 8'h14, 1, 0, 0);
        tick();
        cyc("t1 c6", 0, 0, 0, 0, 0, 0, 1, 0);
        chk("t1 words_done", {27'd0, words_done}, 3);
        tick();
        cyc("t1 c7", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t1 dst9", {24'd0, dst_mem[9]}, 8'h12);
        chk("t1 dst10", {24'd0, dst_mem[10]}, 8'h13);
        chk("t1 dst11", {24'd0, dst_mem[11]}, 8'h14);

        // count = 0: immediate done, never busy
        do_start(0, 0, 0);
        cyc("t2 c1", 0, 0, 0, 0, 0, 0, 1, 0);
        chk("t2 words_done", {27'd0, words_done}, 0);
        tick();
        cyc("t2 c2", 0, 0, 0, 0, 0, 0, 0, 0);

        // start and abort together in IDLE: start wins; count = 1
        abort = 1'b1;
        do_start(3, 12, 1);
        abort = 1'b0;
        cyc("t3 c1", 1, 3, 0, 0, 0, 1, 0, 0);
        tick();
        cyc("t3 c2", 0, 0, 0, 0, 0, 1, 0, 0);
        tick();
        cyc("t3 c3", 0, 0, 1, 12, 8'h13, 1, 0, 0);
        tick();
        cyc("t3 c4", 0, 0, 0, 0, 0, 0, 1, 0);
        chk("t3 words_done", {27'd0, words_done}, 1);

        // abort in IDLE is ignored
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cyc("t4 idle abort", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t4 words_done", {27'd0, words_done}, 1);

        // wrap: src 14, dst 15, 4 words -> reads 14,15,0,1 writes 15,0,1,2
        do_start(14, 15, 4);
        chk("t5 words_done clr", {27'd0, words_done}, 0);
        for (int c = 1; c <= 8; c++) begin
            cyc($sformatf("t5 c%0d", c), c <= 4, (14 + c - 1) & 15,
                (c >= 3 && c <= 6), (c >= 3 && c <= 6) ? ((15 + c - 3) & 15) : 0,
                (c >= 3 && c <= 6) ? (8'h10 + ((14 + c - 3) & 15)) : 0,
                c <= 6, c == 7, 0);
            tick();
        end
        chk("t5 dst15", {24'd0, dst_mem[15]}, 8'h1e);
        chk("t5 dst0", {24'd0, dst_mem[0]}, 8'h1f);
        chk("t5 dst2", {24'd0, dst_mem[2]}, 8'h11);

        // full space: 16 words, src 5, dst 3, no bubbles, done cycle 19
        do_start(5, 3, 16);
        for (int c = 1; c <= 20; c++) begin
            cyc($sformatf("t6 c%0d", c), c <= 16, (5 + c - 1) & 15,
                (c >= 3 && c <= 18), (c >= 3 && c <= 18) ? (c & 15) : 0,
                (c >= 3 && c <= 18) ? (8'h10 + ((5 + c - 3) & 15)) : 0,
                c <= 18, c == 19, 0);
            if (c == 19) chk("t6 words_done", {27'd0, words_done}, 16);
            tick();
        end
        for (int i = 0; i < 16; i++)
            chk($sformatf("t6 dst%0d", (3 + i) & 15), {24'd0, dst_mem[(3 + i) & 15]},
                8'h10 + ((5 + i) & 15));

        // abort at the posedge ending cycle 4 of a 5-word copy
        fill_dst(8'hee);
        do_start(0, 6, 5);
        cyc("t7 c1", 1, 0, 0, 0, 0, 1, 0, 0);
        tick();
        cyc("t7 c2", 1, 1, 0, 0, 0, 1, 0, 0);
        tick();
        cyc("t7 c3", 1, 2, 1, 6, 8'h10, 1, 0, 0);
        tick();
        cyc("t7 c4", 1, 3, 1, 7, 8'h11, 1, 0, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        cyc("t7 c5", 0, 0, 0, 0, 0, 0, 1, 1);
        chk("t7 words_done", {27'd0, words_done}, 2);
        tick();
        cyc("t7 c6", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t7 dst6", {24'd0, dst_mem[6]}, 8'h10);
        chk("t7 dst7", {24'd0, dst_mem[7]}, 8'h11);
        chk("t7 dst8", {24'd0, dst_mem[8]}, 8'hee);

        // reset in cycle 3 of a 5-word copy, then a fresh transfer
        do_start(0, 0, 5);
        tick();
        tick();
        cyc("t8 c3", 1, 2, 1, 0, 8'h10, 1, 0, 0);
        rst = 1'b0;
        #1;
        cyc("t8 in rst", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t8 rst rd_addr", {28'd0, rd_addr}, 0);
        chk("t8 rst words_done", {27'd0, words_done}, 0);
        tick();
        cyc("t8 rst hold", 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        cyc("t8 post rst", 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t8 dst0 kept", {24'd0, dst_mem[0]}, 8'hee);
        do_start(8, 4, 2);
        cyc("t8b c1", 1, 8, 0, 0, 0, 1, 0, 0);
        tick();
        cyc("t8b c2", 1, 9, 0, 0, 0, 1, 0, 0);
        tick();
        cyc("t8b c3", 0, 0, 1, 4, 8'h18, 1, 0, 0);
        tick();
        cyc("t8b c4", 0, 0, 1, 5, 8'h19, 1, 0, 0);
        tick();
        cyc("t8b c5", 0, 0, 0, 0, 0, 0, 1, 0);
        chk("t8b words_done", {27'd0, words_done}, 2);
        tick();
        chk("t8b dst4", {24'd0, dst_mem[4]}, 8'h18);
        chk("t8b dst5", {24'd0, dst_mem[5]}, 8'h19);

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
